// File: rtl/quire_window_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quire_window_arbiter_pkg: shared types and widths for the quire arbiter      |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package quire_window_arbiter_pkg;

  localparam int QUIRE_4_0_WIDTH = 19;
  localparam int POSIT_FRAC_W    = 4;
  localparam int POSIT_SCALE_W   = 4;

  typedef struct packed {
    logic [POSIT_FRAC_W-1:0]  fraction;
    logic [POSIT_SCALE_W-1:0] scale;
    logic                     sign;
    logic                     zero;
    logic                     nar;
    logic                     sow;
    logic                     eow;
  } quire_beat_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage : quire_window_arbiter_pkg
`default_nettype wire

// File: rtl/quire_window_arbiter_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tag_fifo: small owner-tag FIFO, simultaneous push/pop allowed even when full |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == C_FULL_COUNT);
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when a pop frees the slot this cycle
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : tag_fifo
`default_nettype wire

// File: rtl/quire_window_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quire_window_arbiter: window-granular round-robin share of one quire_4_0    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module quire_window_arbiter
  import quire_window_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 4,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_rts_i,
  output logic [N_REQ-1:0]           req_rtr_o,
  input  logic [N_REQ-1:0]           req_sow_i,
  input  logic [N_REQ-1:0]           req_eow_i,
  input  logic [N_REQ*4-1:0]         req_fraction_i,
  input  logic [N_REQ*4-1:0]         req_scale_i,
  input  logic [N_REQ-1:0]           req_sign_i,
  input  logic [N_REQ-1:0]           req_zero_i,
  input  logic [N_REQ-1:0]           req_nar_i,
  input  logic                       q_rtr_i,
  output logic                       q_rts_o,
  output logic                       q_sow_o,
  output logic                       q_eow_o,
  output logic                       q_sign_o,
  output logic                       q_zero_o,
  output logic                       q_nar_o,
  output logic [3:0]                 q_fraction_o,
  output logic [3:0]                 q_scale_o,
  input  logic                       q_rts_i,
  input  logic                       q_sow_i,
  input  logic                       q_eow_i,
  input  logic                       q_nar_i,
  input  logic                       q_sign_i,
  input  logic                       q_zero_i,
  input  logic [QUIRE_4_0_WIDTH-1:0] q_data_i,
  output logic                       q_rtr_o,
  output logic                       res_rts_o,
  input  logic                       res_rtr_i,
  output logic [QUIRE_4_0_WIDTH-1:0] res_data_o,
  output logic                       res_sign_o,
  output logic                       res_zero_o,
  output logic                       res_nar_o,
  output logic [ID_W-1:0]            res_id_o,
  output logic                       proto_err_o
);

  arb_state_t      r_state, w_state_next;
  logic [ID_W-1:0] r_grant_id, r_rr_ptr, w_winner, w_idle_err_id, w_fifo_head;
  logic            w_winner_vld, w_idle_err_vld, w_take_grant;
  logic            r_first_beat, r_active, r_proto_err;
  logic            w_q_accept, w_push, w_set_err;
  logic            w_res_accept, w_pop, w_fifo_full, w_fifo_empty;
  quire_beat_t     w_beat;

  // Beat of the currently (or most recently) granted requester
  always_comb begin
    w_beat.fraction = req_fraction_i[int'(r_grant_id)*POSIT_FRAC_W +: POSIT_FRAC_W];
    w_beat.scale    = req_scale_i[int'(r_grant_id)*POSIT_SCALE_W +: POSIT_SCALE_W];
    w_beat.sign     = req_sign_i[r_grant_id];
    w_beat.zero     = req_zero_i[r_grant_id];
    w_beat.nar      = req_nar_i[r_grant_id];
    w_beat.sow      = req_sow_i[r_grant_id];
    w_beat.eow      = req_eow_i[r_grant_id];
  end

  // Round-robin winner among sow candidates, plus lowest index showing rts without sow
  always_comb begin : p_select
    int idx;
    idx            = 0;
    w_winner_vld   = 1'b0;
    w_winner       = '0;
    w_idle_err_vld = 1'b0;
    w_idle_err_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % N_REQ;
      if (!w_winner_vld && req_rts_i[idx] && req_sow_i[idx]) begin
        w_winner_vld = 1'b1;
        w_winner     = ID_W'(idx);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rts_i[i] && !req_sow_i[i]) begin
        w_idle_err_vld = 1'b1;
        w_idle_err_id  = ID_W'(i);
      end
    end
  end

  assign q_fraction_o = w_beat.fraction;
  assign q_scale_o    = w_beat.scale;
  assign q_sign_o     = w_beat.sign;
  assign q_zero_o     = w_beat.zero;
  assign q_nar_o      = w_beat.nar;
  assign q_sow_o      = w_beat.sow;
  assign q_eow_o      = w_beat.eow;

  assign w_take_grant = (r_state == ST_IDLE) && w_winner_vld && !w_fifo_full;
  assign w_q_accept   = (r_state == ST_LOCKED) && req_rts_i[r_grant_id] && q_rtr_i;

  always_comb begin
    w_state_next = r_state;
    req_rtr_o    = '0;
    q_rts_o      = 1'b0;
    w_push       = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_active && w_idle_err_vld) begin
          req_rtr_o[w_idle_err_id] = 1'b1;
          w_set_err                = 1'b1;
        end
        if (w_take_grant) w_state_next = ST_LOCKED;
      end
      ST_LOCKED: begin
        q_rts_o               = req_rts_i[r_grant_id];
        req_rtr_o[r_grant_id] = q_rtr_i;
        if (w_q_accept) begin
          if (w_beat.sow && !r_first_beat) w_set_err = 1'b1;
          if (w_beat.eow) begin
            w_push       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result side: intermediate quire beats are sunk here, eow beats go downstream
  assign res_rts_o    = r_active & q_rts_i & q_eow_i;
  assign q_rtr_o      = r_active & (q_eow_i ? res_rtr_i : 1'b1);
  assign w_res_accept = res_rts_o & res_rtr_i;
  assign w_pop        = w_res_accept & ~w_fifo_empty;
  assign res_data_o   = q_data_i;
  assign res_sign_o   = q_sign_i;
  assign res_zero_o   = q_zero_i;
  assign res_nar_o    = q_nar_i;
  assign res_id_o     = w_fifo_empty ? '0 : w_fifo_head;
  assign proto_err_o  = r_proto_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_rr_ptr     <= '0;
      r_first_beat <= 1'b0;
      r_active     <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_active <= 1'b1;
      r_state  <= w_state_next;
      if (w_take_grant) begin
        r_grant_id   <= w_winner;
        r_first_beat <= 1'b1;
      end else if (w_q_accept) begin
        r_first_beat <= 1'b0;
      end
      if (w_push) begin
        r_rr_ptr <= (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
      end
      if (w_set_err || (w_res_accept && w_fifo_empty)) r_proto_err <= 1'b1;
    end
  end

  tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (r_grant_id),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

endmodule : quire_window_arbiter
`default_nettype wire

// File: tb/tb_quire_window_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_quire_window_arbiter: directed vectors against a behavioural quire model |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_quire_window_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_REQ-1:0]  req_rts, req_rtr, req_sow, req_eow, req_sign, req_zero, req_nar;
  logic [N_REQ*4-1:0] req_fraction, req_scale;
  logic              q_rtr_i;
  logic              q_rts_o, q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_nar_o;
  logic [3:0]        q_fraction_o, q_scale_o;
  logic              q_rts_i, q_sow_i, q_eow_i, q_nar_i, q_sign_i, q_zero_i;
  logic [18:0]       q_data_i;
  logic              q_rtr_o;
  logic              res_rts_o, res_rtr_i;
  logic [18:0]       res_data_o;
  logic              res_sign_o, res_zero_o, res_nar_o;
  logic [ID_W-1:0]   res_id_o;
  logic              proto_err_o;

  always #5 clk = ~clk;
  assign q_rtr_i = 1'b1;

  quire_window_arbiter #(.N_REQ(N_REQ), .TAG_DEPTH(4), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rts_i(req_rts), .req_rtr_o(req_rtr), .req_sow_i(req_sow), .req_eow_i(req_eow),
    .req_fraction_i(req_fraction), .req_scale_i(req_scale), .req_sign_i(req_sign),
    .req_zero_i(req_zero), .req_nar_i(req_nar),
    .q_rtr_i(q_rtr_i), .q_rts_o(q_rts_o), .q_sow_o(q_sow_o), .q_eow_o(q_eow_o),
    .q_sign_o(q_sign_o), .q_zero_o(q_zero_o), .q_nar_o(q_nar_o),
    .q_fraction_o(q_fraction_o), .q_scale_o(q_scale_o),
    .q_rts_i(q_rts_i), .q_sow_i(q_sow_i), .q_eow_i(q_eow_i), .q_nar_i(q_nar_i),
    .q_sign_i(q_sign_i), .q_zero_i(q_zero_i), .q_data_i(q_data_i), .q_rtr_o(q_rtr_o),
    .res_rts_o(res_rts_o), .res_rtr_i(res_rtr_i), .res_data_o(res_data_o),
    .res_sign_o(res_sign_o), .res_zero_o(res_zero_o), .res_nar_o(res_nar_o),
    .res_id_o(res_id_o), .proto_err_o(proto_err_o)
  );

  // Behavioural quire_4_0: 4 fractional bits, elastic output queue, one output beat per input beat
  typedef struct packed {
    logic [18:0] data;
    logic sow, eow, sign, zero, nar;
  } qout_t;

  qout_t       qq[$];
  qout_t       qb;
  logic [18:0] acc;
  logic        acc_nar;
  int          q_in_count;

  function automatic logic [18:0] contrib(logic [3:0] f, logic [3:0] s, logic sg, logic z);
    logic [18:0] m;
    int sc;
    sc = int'($signed(s));
    m  = {14'd0, 1'b1, f};
    if (sc >= 0) m = m << sc;
    else         m = m >> (-sc);
    if (z) m = '0;
    return sg ? -m : m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qq.delete();
      acc = '0;
      acc_nar = 1'b0;
      q_in_count = 0;
      q_rts_i <= 1'b0; q_sow_i <= 1'b0; q_eow_i <= 1'b0;
      q_sign_i <= 1'b0; q_zero_i <= 1'b0; q_nar_i <= 1'b0; q_data_i <= '0;
    end else begin
      if (q_rts_i && q_rtr_o && qq.size() > 0) void'(qq.pop_front());
      if (q_rts_o && q_rtr_i) begin
        acc     = (q_sow_o ? 19'd0 : acc) + contrib(q_fraction_o, q_scale_o, q_sign_o, q_zero_o);
        acc_nar = (q_sow_o ? 1'b0 : acc_nar) | q_nar_o;
        qb.data = acc; qb.sow = q_sow_o; qb.eow = q_eow_o;
        qb.sign = acc[18]; qb.zero = (acc == 19'd0); qb.nar = acc_nar;
        qq.push_back(qb);
        q_in_count++;
      end
      if (qq.size() > 0) begin
        q_rts_i <= 1'b1; q_data_i <= qq[0].data; q_sow_i <= qq[0].sow; q_eow_i <= qq[0].eow;
        q_sign_i <= qq[0].sign; q_zero_i <= qq[0].zero; q_nar_i <= qq[0].nar;
      end else begin
        q_rts_i <= 1'b0;
      end
    end
  end

  // Result monitor: a beat showing rts&rtr at the falling edge is taken on the next rising edge
  typedef struct packed {
    logic [18:0]     data;
    logic            sign;
    logic [ID_W-1:0] id;
  } res_t;

  res_t res_q[$];
  res_t rcap;

  always @(negedge clk) begin
    if (res_rts_o && res_rtr_i) begin
      rcap.data = res_data_o; rcap.sign = res_sign_o; rcap.id = res_id_o;
      res_q.push_back(rcap);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int id, input logic rts, input logic sow, input logic eow,
                         input logic [3:0] frac, input logic [3:0] scale, input logic sign);
    req_rts[id] = rts; req_sow[id] = sow; req_eow[id] = eow; req_sign[id] = sign;
    req_fraction[id*4 +: 4] = frac; req_scale[id*4 +: 4] = scale;
  endtask

  task automatic send_window(input int id, input int beats, input logic [3:0] frac,
                             input logic [3:0] scale, input logic sign, output logic ok);
    logic acc_b;
    ok = 1'b1;
    for (int b = 0; b < beats && ok; b++) begin
      set_req(id, 1'b1, b == 0, b == beats - 1, frac, scale, sign);
      acc_b = 1'b0;
      for (int c = 0; c < 60 && !acc_b; c++) begin
        @(negedge clk);
        if (req_rtr[id]) acc_b = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!acc_b) ok = 1'b0;
    end
    set_req(id, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic wait_results(input int n);
    for (int c = 0; c < 100 && res_q.size() < n; c++) step(1);
  endtask

  // Raises one-beat windows on every requester in mask and records the grant order
  task automatic race(input logic [N_REQ-1:0] mask, inout int order[$]);
    logic [N_REQ-1:0] pending;
    int taken;
    pending = mask;
    for (int i = 0; i < N_REQ; i++)
      if (mask[i]) set_req(i, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
    for (int c = 0; c < 100 && pending != '0; c++) begin
      taken = -1;
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++)
        if (pending[i] && req_rtr[i]) taken = i;
      @(posedge clk);
      #1;
      if (taken >= 0) begin
        order.push_back(taken);
        pending[taken] = 1'b0;
        set_req(taken, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_rtr"},   32'(req_rtr), 32'h0);
    check({tag, " q_rts"},     32'(q_rts_o), 32'h0);
    check({tag, " q_rtr"},     32'(q_rtr_o), 32'h0);
    check({tag, " res_rts"},   32'(res_rts_o), 32'h0);
    check({tag, " res_id"},    32'(res_id_o), 32'h0);
    check({tag, " proto_err"}, 32'(proto_err_o), 32'h0);
  endtask

  typedef struct {
    int          id;
    int          beats;
    logic [3:0]  frac;
    logic [3:0]  scale;
    logic        sign;
    logic [18:0] exp_data;
    logic        exp_sign;
  } vec_t;

  vec_t vt[5];
  int   order[$];
  int   exp_order[4];
  int   exp_ids[5];
  logic [18:0] exp_fifo_data[5];
  int   base_cnt;
  logic ok, stalled;

  initial begin
    vt[0] = '{0, 3, 4'd0,  4'd0,  1'b0, 19'd48,      1'b0};
    vt[1] = '{2, 1, 4'd0,  4'hF,  1'b1, 19'h7FFF8,   1'b1};
    vt[2] = '{1, 2, 4'd8,  4'd1,  1'b0, 19'd96,      1'b0};
    vt[3] = '{3, 1, 4'd4,  4'd2,  1'b0, 19'd80,      1'b0};
    vt[4] = '{1, 1, 4'd12, 4'hE,  1'b0, 19'd7,       1'b0};
    exp_order     = '{1, 3, 1, 3};
    exp_ids       = '{0, 1, 2, 3, 1};
    exp_fifo_data = '{19'd16, 19'd17, 19'd18, 19'd19, 19'd21};

    rst_n = 1'b0;
    req_rts = '0; req_sow = '0; req_eow = '0; req_sign = '0; req_zero = '0; req_nar = '0;
    req_fraction = '0; req_scale = '0; res_rtr_i = 1'b1;
    #12;
    check_reset_outputs("reset");
    step(1);
    rst_n = 1'b1;
    step(2);

    // Tie between 1 and 3 from rr_ptr=0, twice
    race(4'b1010, order);
    race(4'b1010, order);
    check("tie count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check($sformatf("tie order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));
    wait_results(4);
    check("tie results", 32'(res_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < res_q.size(); i++)
      check($sformatf("tie res_id[%0d]", i), 32'(res_q[i].id), 32'(exp_order[i]));
    res_q.delete();

    // Table of single windows
    for (int v = 0; v < 5; v++) begin
      base_cnt = q_in_count;
      send_window(vt[v].id, vt[v].beats, vt[v].frac, vt[v].scale, vt[v].sign, ok);
      check($sformatf("vec%0d accepted", v), 32'(ok), 32'd1);
      wait_results(1);
      step(3);
      check($sformatf("vec%0d result count", v), 32'(res_q.size()), 32'd1);
      check($sformatf("vec%0d quire beats", v), 32'(q_in_count - base_cnt), 32'(vt[v].beats));
      check($sformatf("vec%0d q_rts idle", v), 32'(q_rts_o), 32'd0);
      if (res_q.size() > 0) begin
        check($sformatf("vec%0d res_data", v), 32'(res_q[0].data), 32'(vt[v].exp_data));
        check($sformatf("vec%0d res_sign", v), 32'(res_q[0].sign), 32'(vt[v].exp_sign));
        check($sformatf("vec%0d res_id", v), 32'(res_q[0].id), 32'(vt[v].id));
      end
      res_q.delete();
    end
    check("no proto_err yet", 32'(proto_err_o), 32'd0);

    // FIFO full: four tags in flight stall the fifth grant until results drain
    res_rtr_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_window(exp_ids[k], 1, 4'(k), 4'd0, 1'b0, ok);
      check($sformatf("fill %0d accepted", k), 32'(ok), 32'd1);
    end
    set_req(1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
    stalled = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_rtr[1] || q_rts_o) stalled = 1'b0;
      @(posedge clk);
      #1;
    end
    check("fifo full stalls grant", 32'(stalled), 32'd1);
    check("no result while blocked", 32'(res_q.size()), 32'd0);
    res_rtr_i = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (req_rtr[1]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check("fifth grant after drain", 32'(ok), 32'd1);
    wait_results(5);
    step(2);
    check("drain count", 32'(res_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < res_q.size(); i++) begin
      check($sformatf("drain id[%0d]", i), 32'(res_q[i].id), 32'(exp_ids[i]));
      check($sformatf("drain data[%0d]", i), 32'(res_q[i].data), 32'(exp_fifo_data[i]));
    end
    res_q.delete();

    // rts without sow in IDLE is consumed and flagged
    base_cnt = q_in_count;
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 1'b0);
    @(negedge clk);
    check("proto rtr", 32'(req_rtr), 32'h1);
    check("proto no q beat", 32'(q_rts_o), 32'd0);
    step(1);
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    check("proto_err set", 32'(proto_err_o), 32'd1);
    step(4);
    check("proto_err sticky", 32'(proto_err_o), 32'd1);
    check("proto quire untouched", 32'(q_in_count - base_cnt), 32'd0);

    // Reset in the middle of a window from requester 1
    send_window(1, 1, 4'd0, 4'd0, 1'b0, ok);
    set_req(1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (req_rtr[1]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check("mid-window first beat", 32'(ok), 32'd1);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);
    res_q.delete();
    send_window(1, 2, 4'd0, 4'd0, 1'b0, ok);
    check("post-reset accepted", 32'(ok), 32'd1);
    wait_results(1);
    step(2);
    check("post-reset result count", 32'(res_q.size()), 32'd1);
    if (res_q.size() > 0) begin
      check("post-reset res_data", 32'(res_q[0].data), 32'd32);
      check("post-reset res_id", 32'(res_q[0].id), 32'd1);
    end
    check("post-reset proto_err", 32'(proto_err_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_quire_window_arbiter
`default_nettype wire
